moving_average_filter: RTL and testbench

- Streaming boxcar (moving-sum) filter; accepts one unsigned sample per clock, no handshake.
- Outputs the running sum of the last ORDER input samples; the consumer divides by ORDER (shift when ORDER is a power of two) to get the mean.
- Sits directly on a free-running sample stream, e.g. smoothing noisy ADC data before downstream processing.

---
 rtl/moving_average_filter.sv | 57 +++++
 tb/tb_moving_average_filter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_filter.sv
// Streaming boxcar filter: result is the registered sum of the last ORDER
// unsigned input samples. One sample is taken on every rising clock edge, and
// the mean is result / ORDER.
//
// Ports:
//   clk    - clock; all state updates on the rising edge
//   nrst   - asynchronous active-low reset; clears taps, accumulator and result
//   data   - unsigned input sample, taken every edge while nrst = 1
//   result - registered sum of the last ORDER samples (warm-up samples count as 0)
module moving_average_filter #(
   parameter int unsigned INPUT_WIDTH  = 16,
   parameter int unsigned OUTPUT_WIDTH = 18,
   parameter int unsigned ORDER        = 4
) (
   input  logic                    clk,
   input  logic                    nrst,
   input  logic [INPUT_WIDTH-1:0]  data,
   output logic [OUTPUT_WIDTH-1:0] result
);

   // Narrowest sum that can hold ORDER full-scale samples without wrapping
   localparam int unsigned MIN_OUT_W = INPUT_WIDTH + $clog2(ORDER);

   // Reject parameter sets that could overflow the sum or have an empty window
   generate
      if (ORDER == 0) begin : g_bad_order
         $error("moving_average_filter: ORDER must be >= 1");
      end
      if (OUTPUT_WIDTH < MIN_OUT_W) begin : g_bad_width
         $error("moving_average_filter: OUTPUT_WIDTH too small for INPUT_WIDTH and ORDER");
      end
   endgenerate

   logic [INPUT_WIDTH-1:0]  taps [ORDER];
   logic [OUTPUT_WIDTH-1:0] acc;

   // Delay line plus recursive running sum. taps[ORDER-1] is the sample that
   // leaves the window on this edge. acc always contains that sample, so the
   // subtraction cannot underflow.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < int'(ORDER); i++) begin
            taps[i] <= '0;
         end
         acc <= '0;
      end else begin
         taps[0] <= data;
         for (int i = 1; i < int'(ORDER); i++) begin
            taps[i] <= taps[i-1];
         end
         acc <= acc + OUTPUT_WIDTH'(data) - OUTPUT_WIDTH'(taps[ORDER-1]);
      end
   end

   assign result = acc;

endmodule

// File: tb/tb_moving_average_filter.sv
module tb_moving_average_filter;

   localparam int unsigned IW = 16;
   localparam int unsigned OW = 18;

   logic          clk;
   logic          nrst;
   logic [IW-1:0] data;
   logic [OW-1:0] result;

   moving_average_filter #(
      .INPUT_WIDTH (IW),
      .OUTPUT_WIDTH(OW),
      .ORDER       (4)
   ) dut (
      .clk   (clk),
      .nrst  (nrst),
      .data  (data),
      .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] exp;
      bit            stat;
      int            id;
   } item_t;

   item_t q[$];
   int    total = 0;
   int    bad   = 0;
   int    n_issued = 0;

   // Output statistics over the noisy run, collected by the monitor
   real   out_sum = 0.0;
   real   out_sq  = 0.0;
   int    out_n   = 0;

   // Apply one sample before the next rising edge and queue the sum expected after it
   task automatic drive(input logic [IW-1:0] d, input logic [OW-1:0] e, input bit st);
      item_t it;
      @(negedge clk);
      nrst = 1'b1;
      data = d;
      it.exp  = e;
      it.stat = st;
      it.id   = n_issued;
      n_issued++;
      q.push_back(it);
   endtask

   // Hold reset for n edges with nonzero data; result must stay 0
   task automatic do_reset(input int n);
      item_t it;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         nrst = 1'b0;
         data = 16'd1234;
         it.exp  = '0;
         it.stat = 1'b0;
         it.id   = n_issued;
         n_issued++;
         q.push_back(it);
      end
   endtask

   // Reset asserted between edges must clear result without any clock edge
   task automatic async_check(input string name);
      @(negedge clk);
      #2;
      nrst = 1'b0;
      #1;
      total++;
      if (result !== '0) begin
         bad++;
         $display("FAIL %s: result=%0d without clock edge, want 0", name, result);
      end
   endtask

   // Monitor: the DUT offers a new sum after every edge; compare it with the oldest expectation
   initial begin : monitor
      item_t it;
      real   r;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            it = q.pop_front();
            total++;
            if (result !== it.exp) begin
               bad++;
               $display("FAIL res#%0d: result=%0d want %0d", it.id, result, it.exp);
            end
            if (it.stat) begin
               r = real'(result) / 4.0;
               out_sum += r;
               out_sq  += r * r;
               out_n++;
            end
         end
      end
   end

   initial begin : stimulus
      int  win[$];
      int  wsum;
      int  v;
      int  budget;
      real g;
      real in_sum, in_sq, in_var, out_var;
      logic [OW-1:0] ramp_exp [6];

      nrst = 1'b0;
      data = 16'd1234;

      // Reset held for 5 clocks
      do_reset(5);

      // Step: 100 constant
      drive(16'd100, 18'd100, 1'b0);
      drive(16'd100, 18'd200, 1'b0);
      drive(16'd100, 18'd300, 1'b0);
      drive(16'd100, 18'd400, 1'b0);
      drive(16'd100, 18'd400, 1'b0);
      drive(16'd100, 18'd400, 1'b0);

      // Mid-stream asynchronous reset, then warm-up restarts
      async_check("async_clear_from_400");
      do_reset(1);
      drive(16'd100, 18'd100, 1'b0);
      drive(16'd100, 18'd200, 1'b0);
      drive(16'd100, 18'd300, 1'b0);
      drive(16'd100, 18'd400, 1'b0);

      // Ramp 1..6
      do_reset(2);
      ramp_exp[0] = 18'd1;  ramp_exp[1] = 18'd3;  ramp_exp[2] = 18'd6;
      ramp_exp[3] = 18'd10; ramp_exp[4] = 18'd14; ramp_exp[5] = 18'd18;
      for (int k = 0; k < 6; k++) drive(IW'(k + 1), ramp_exp[k], 1'b0);

      // Full-scale impulse: exactly 4 cycles of 65535, then 0
      do_reset(2);
      drive(16'hFFFF, 18'd65535, 1'b0);
      drive(16'd0,    18'd65535, 1'b0);
      drive(16'd0,    18'd65535, 1'b0);
      drive(16'd0,    18'd65535, 1'b0);
      drive(16'd0,    18'd0,     1'b0);
      drive(16'd0,    18'd0,     1'b0);

      // Constant full scale settles at 0x3FFFC without wrapping
      drive(16'hFFFF, 18'd65535,  1'b0);
      drive(16'hFFFF, 18'd131070, 1'b0);
      drive(16'hFFFF, 18'd196605, 1'b0);
      drive(16'hFFFF, 18'h3FFFC,  1'b0);
      drive(16'hFFFF, 18'h3FFFC,  1'b0);
      drive(16'hFFFF, 18'h3FFFC,  1'b0);
      async_check("async_clear_from_full");

      // Noisy slow sine around 30, checked against a sliding window of the last 4 samples
      do_reset(1);
      in_sum = 0.0;
      in_sq  = 0.0;
      for (int i = 0; i < 10000; i++) begin
         g = 0.0;
         repeat (12) g += real'($urandom_range(0, 1000)) / 1000.0;
         g -= 6.0;
         v = $rtoi($sin(real'(i) * 1.0e-4) + 10.0 + (100.0 + 10.0 * g) / 5.0);
         if (v < 0) v = 0;
         win.push_back(v);
         if (win.size() > 4) void'(win.pop_front());
         wsum = 0;
         foreach (win[j]) wsum += win[j];
         in_sum += real'(v);
         in_sq  += real'(v) * real'(v);
         drive(IW'(v), OW'(wsum), (i >= 3));
      end

      // Bounded drain of the scoreboard
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      #2;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d results never appeared, want 0 pending", q.size());
      end

      // Smoothing must reduce variance
      in_var  = in_sq / 10000.0 - (in_sum / 10000.0) * (in_sum / 10000.0);
      out_var = 0.0;
      if (out_n > 0)
         out_var = out_sq / real'(out_n) - (out_sum / real'(out_n)) * (out_sum / real'(out_n));
      total++;
      if (!(out_n > 0 && out_var < in_var)) begin
         bad++;
         $display("FAIL variance: output var=%f (n=%0d) want below input var=%f", out_var, out_n, in_var);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
